// File: rtl/lock_sequencer_if.sv
`default_nettype none
// ============================================================================
// lock_sequencer_if : button/datapath handshake bundle for lock_sequencer
// Rev 1.0
// ============================================================================
interface lock_sequencer_if #(
  parameter int DIGIT_W = 2
);
  logic               input_btn;
  logic               store_btn;
  logic               submit_btn;
  logic [DIGIT_W-1:0] digit;
  logic               cmp_done;
  logic               match;
  logic               wr_in;
  logic               wr_sys;
  logic [2:0]         wr_idx;
  logic [DIGIT_W-1:0] wr_data;
  logic               clr_in;
  logic               cmp_req;
  logic               unlock;
  logic               locked;
  logic               pw_set;
  logic [2:0]         attempts;
  logic [7:0]         sec_left;
  logic [3:0]         state;
  logic               cmp_err;

  modport slave (
    input  input_btn, store_btn, submit_btn, digit, cmp_done, match,
    output wr_in, wr_sys, wr_idx, wr_data, clr_in, cmp_req, unlock,
           locked, pw_set, attempts, sec_left, state, cmp_err
  );

  modport master (
    output input_btn, store_btn, submit_btn, digit, cmp_done, match,
    input  wr_in, wr_sys, wr_idx, wr_data, clr_in, cmp_req, unlock,
           locked, pw_set, attempts, sec_left, state, cmp_err
  );
endinterface
`default_nettype wire

// File: rtl/lock_sequencer.sv
`default_nettype none
// ============================================================================
// lock_sequencer : button-edge sequencer with compare handshake, lockout and unlock timer
// Rev 1.0
// ============================================================================
module lock_sequencer #(
  parameter int PW_LEN       = 4,
  parameter int DIGIT_W      = 2,
  parameter int MAX_ATTEMPTS = 3,
  parameter int TICK_DIV     = 50_000_000,
  parameter int LOCK_BASE_S  = 5,
  parameter int UNLOCK_S     = 10,
  parameter int CMP_TIMEOUT  = 16
) (
  input  wire logic        clk,
  input  wire logic        system_reset,
  lock_sequencer_if.slave  bus
);

  localparam int CNT_W   = $clog2(PW_LEN + 1);
  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WAIT_W  = (CMP_TIMEOUT > 1) ? $clog2(CMP_TIMEOUT) : 1;

  localparam logic [CNT_W-1:0]   C_CNT_FULL  = CNT_W'(PW_LEN);
  localparam logic [PRESC_W-1:0] C_PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [WAIT_W-1:0]  C_WAIT_MAX  = WAIT_W'(CMP_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ENTER   = 4'd1,
    S_STORE   = 4'd2,
    S_COMPARE = 4'd3,
    S_FAIL    = 4'd4,
    S_UNLOCK  = 4'd5,
    S_LOCKOUT = 4'd6
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           attempts_q, attempts_d;
  logic [1:0]           lock_level_q, lock_level_d;
  logic                 pw_set_q, pw_set_d;
  logic [7:0]           sec_left_q, sec_left_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [2:0]           wr_idx_q, wr_idx_d;
  logic [DIGIT_W-1:0]   wr_data_q, wr_data_d;
  logic                 wr_in_q, wr_in_d;
  logic                 wr_sys_q, wr_sys_d;
  logic                 clr_in_q, clr_in_d;
  logic                 cmp_req_q, cmp_req_d;
  logic                 cmp_err_q, cmp_err_d;
  logic                 unlock_q, unlock_d;
  logic                 locked_q, locked_d;
  logic                 input_prev_q, store_prev_q, submit_prev_q;

  logic                 submit_ev, input_ev, store_ev;
  logic                 tick, expire;
  logic [15:0]          lock_shift;
  logic [7:0]           lock_secs;

  // Only the highest-priority rising edge is acted on in any one cycle.
  assign submit_ev = bus.submit_btn & ~submit_prev_q;
  assign input_ev  = bus.input_btn  & ~input_prev_q  & ~submit_ev;
  assign store_ev  = bus.store_btn  & ~store_prev_q  & ~submit_ev & ~input_ev;

  assign lock_shift = 16'(LOCK_BASE_S) << lock_level_q;
  assign lock_secs  = (lock_shift > 16'd255) ? 8'd255 : lock_shift[7:0];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    attempts_d   = attempts_q;
    lock_level_d = lock_level_q;
    pw_set_d     = pw_set_q;
    sec_left_d   = sec_left_q;
    presc_d      = presc_q;
    wait_d       = '0;
    wr_idx_d     = wr_idx_q;
    wr_data_d    = wr_data_q;
    wr_in_d      = 1'b0;
    wr_sys_d     = 1'b0;
    clr_in_d     = 1'b0;
    cmp_req_d    = 1'b0;
    cmp_err_d    = 1'b0;
    tick         = (presc_q == C_PRESC_MAX);
    expire       = 1'b0;

    if (state_q == S_UNLOCK || state_q == S_LOCKOUT) begin
      if (tick) begin
        presc_d    = '0;
        sec_left_d = sec_left_q - 8'd1;
        expire     = (sec_left_q <= 8'd1);
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (store_ev && !pw_set_q) begin
          wr_sys_d  = 1'b1;
          wr_idx_d  = 3'd0;
          wr_data_d = bus.digit;
          cnt_d     = CNT_W'(1);
          state_d   = S_STORE;
        end else if (input_ev && pw_set_q) begin
          wr_in_d   = 1'b1;
          wr_idx_d  = 3'd0;
          wr_data_d = bus.digit;
          cnt_d     = CNT_W'(1);
          state_d   = S_ENTER;
        end
      end

      S_ENTER: begin
        if (submit_ev) begin
          if (cnt_q == C_CNT_FULL) begin
            cmp_req_d = 1'b1;
            state_d   = S_COMPARE;
          end else begin
            state_d = S_FAIL;
          end
        end else if (input_ev && cnt_q < C_CNT_FULL) begin
          wr_in_d   = 1'b1;
          wr_idx_d  = 3'(cnt_q);
          wr_data_d = bus.digit;
          cnt_d     = cnt_q + 1'b1;
        end
      end

      S_STORE: begin
        if (submit_ev) begin
          if (cnt_q == C_CNT_FULL) begin
            pw_set_d = 1'b1;
            clr_in_d = 1'b1;
            state_d  = S_IDLE;
          end
        end else if (store_ev && cnt_q < C_CNT_FULL) begin
          wr_sys_d  = 1'b1;
          wr_idx_d  = 3'(cnt_q);
          wr_data_d = bus.digit;
          cnt_d     = cnt_q + 1'b1;
        end
      end

      S_COMPARE: begin
        if (bus.cmp_done) begin
          if (bus.match) begin
            attempts_d   = 3'd0;
            lock_level_d = 2'd0;
            sec_left_d   = 8'(UNLOCK_S);
            presc_d      = '0;
            state_d      = S_UNLOCK;
          end else begin
            state_d = S_FAIL;
          end
        end else if (wait_q == C_WAIT_MAX) begin
          cmp_err_d = 1'b1;
          state_d   = S_FAIL;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_FAIL: begin
        if (({1'b0, attempts_q} + 4'd1) < 4'(MAX_ATTEMPTS)) begin
          attempts_d = attempts_q + 3'd1;
          clr_in_d   = 1'b1;
          state_d    = S_IDLE;
        end else begin
          attempts_d   = 3'd0;
          sec_left_d   = lock_secs;
          presc_d      = '0;
          lock_level_d = (lock_level_q == 2'd3) ? 2'd3 : lock_level_q + 2'd1;
          state_d      = S_LOCKOUT;
        end
      end

      S_UNLOCK: begin
        if (expire || submit_ev) begin
          clr_in_d = 1'b1;
          state_d  = S_IDLE;
        end else if (store_ev) begin
          wr_sys_d  = 1'b1;
          wr_idx_d  = 3'd0;
          wr_data_d = bus.digit;
          cnt_d     = CNT_W'(1);
          state_d   = S_STORE;
        end
      end

      S_LOCKOUT: begin
        if (expire) begin
          clr_in_d = 1'b1;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // The countdown only has meaning while a timed state is held.
    if (state_d != S_UNLOCK && state_d != S_LOCKOUT) begin
      sec_left_d = 8'd0;
      presc_d    = '0;
    end

    unlock_d = (state_d == S_UNLOCK);
    locked_d = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (system_reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      attempts_q    <= 3'd0;
      lock_level_q  <= 2'd0;
      pw_set_q      <= 1'b0;
      sec_left_q    <= 8'd0;
      presc_q       <= '0;
      wait_q        <= '0;
      wr_idx_q      <= 3'd0;
      wr_data_q     <= '0;
      wr_in_q       <= 1'b0;
      wr_sys_q      <= 1'b0;
      clr_in_q      <= 1'b0;
      cmp_req_q     <= 1'b0;
      cmp_err_q     <= 1'b0;
      unlock_q      <= 1'b0;
      locked_q      <= 1'b0;
      // Held high so a button pressed through reset yields no edge.
      input_prev_q  <= 1'b1;
      store_prev_q  <= 1'b1;
      submit_prev_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      attempts_q    <= attempts_d;
      lock_level_q  <= lock_level_d;
      pw_set_q      <= pw_set_d;
      sec_left_q    <= sec_left_d;
      presc_q       <= presc_d;
      wait_q        <= wait_d;
      wr_idx_q      <= wr_idx_d;
      wr_data_q     <= wr_data_d;
      wr_in_q       <= wr_in_d;
      wr_sys_q      <= wr_sys_d;
      clr_in_q      <= clr_in_d;
      cmp_req_q     <= cmp_req_d;
      cmp_err_q     <= cmp_err_d;
      unlock_q      <= unlock_d;
      locked_q      <= locked_d;
      input_prev_q  <= bus.input_btn;
      store_prev_q  <= bus.store_btn;
      submit_prev_q <= bus.submit_btn;
    end
  end

  assign bus.wr_in    = wr_in_q;
  assign bus.wr_sys   = wr_sys_q;
  assign bus.wr_idx   = wr_idx_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.clr_in   = clr_in_q;
  assign bus.cmp_req  = cmp_req_q;
  assign bus.unlock   = unlock_q;
  assign bus.locked   = locked_q;
  assign bus.pw_set   = pw_set_q;
  assign bus.attempts = attempts_q;
  assign bus.sec_left = sec_left_q;
  assign bus.state    = state_q;
  assign bus.cmp_err  = cmp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lock_sequencer.sv
`default_nettype none
// ============================================================================
// tb_lock_sequencer : directed scenarios for lock_sequencer with TICK_DIV=4
// Rev 1.0
// ============================================================================
module tb_lock_sequencer;

  logic clk = 1'b0;
  logic system_reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cmp_req_cnt = 0;

  logic       p_wr_in, p_wr_sys, p_cmp_req, p_unlock;
  logic [2:0] p_idx;
  logic [1:0] p_data;
  logic [3:0] p_state;

  lock_sequencer_if #(.DIGIT_W(2)) bus ();

  lock_sequencer #(
    .PW_LEN(4), .DIGIT_W(2), .MAX_ATTEMPTS(3), .TICK_DIV(4),
    .LOCK_BASE_S(5), .UNLOCK_S(10), .CMP_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .system_reset(system_reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!system_reset && bus.cmp_req) cmp_req_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 500000", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // which: 0 = input, 1 = store, 2 = submit. Captures outputs one cycle after the edge.
  task automatic press(input int which, input logic [1:0] d);
    bus.digit = d;
    case (which)
      0: bus.input_btn  = 1'b1;
      1: bus.store_btn  = 1'b1;
      default: bus.submit_btn = 1'b1;
    endcase
    step();
    p_wr_in   = bus.wr_in;
    p_wr_sys  = bus.wr_sys;
    p_idx     = bus.wr_idx;
    p_data    = bus.wr_data;
    p_cmp_req = bus.cmp_req;
    p_state   = bus.state;
    p_unlock  = bus.unlock;
    bus.input_btn  = 1'b0;
    bus.store_btn  = 1'b0;
    bus.submit_btn = 1'b0;
    step();
  endtask

  // Enter 1,2,3,0, submit, answer the compare with match=m, then one more cycle.
  task automatic attempt(input logic m);
    press(0, 2'd1); press(0, 2'd2); press(0, 2'd3); press(0, 2'd0);
    press(2, 2'd0);
    bus.cmp_done = 1'b1; bus.match = m;
    step();
    bus.cmp_done = 1'b0; bus.match = 1'b0;
    step();
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.state != 4'd0 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    bus.store_btn = 1'b1;
    system_reset = 1'b1;
    step(); step();
    checks++; if (bus.state !== 4'd0 || bus.unlock !== 1'b0 || bus.locked !== 1'b0 || bus.pw_set !== 1'b0) begin
      errors++; $display("FAIL reset_state: state=%0d unlock=%b locked=%b pw_set=%b, required 0/0/0/0", bus.state, bus.unlock, bus.locked, bus.pw_set); end
    checks++; if (bus.attempts !== 3'd0 || bus.sec_left !== 8'd0 || bus.wr_sys !== 1'b0 || bus.cmp_req !== 1'b0 || bus.cmp_err !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: attempts=%0d sec_left=%0d wr_sys=%b cmp_req=%b cmp_err=%b, required all 0", bus.attempts, bus.sec_left, bus.wr_sys, bus.cmp_req, bus.cmp_err); end
    system_reset = 1'b0;
    step(); step();
    checks++; if (bus.state !== 4'd0 || bus.wr_sys !== 1'b0) begin
      errors++; $display("FAIL held_button: state=%0d wr_sys=%b, required state 0 wr_sys 0", bus.state, bus.wr_sys); end
    bus.store_btn = 1'b0;
    step();
  endtask

  task automatic test_store();
    logic [1:0] digs [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      press(1, digs[i]);
      checks++; if (p_wr_sys !== 1'b1 || p_idx !== 3'(i) || p_data !== digs[i] || p_state !== 4'd2) begin
        errors++; $display("FAIL store_write%0d: wr_sys=%b idx=%0d data=%0d state=%0d, required 1/%0d/%0d/2", i, p_wr_sys, p_idx, p_data, p_state, i, digs[i]); end
      checks++; if (bus.wr_sys !== 1'b0) begin
        errors++; $display("FAIL store_pulse%0d: wr_sys=%b one cycle later, required 0", i, bus.wr_sys); end
      if (i == 1) begin
        press(2, 2'd0);
        checks++; if (bus.state !== 4'd2 || bus.pw_set !== 1'b0) begin
          errors++; $display("FAIL store_early_submit: state=%0d pw_set=%b, required 2/0", bus.state, bus.pw_set); end
      end
    end
    press(2, 2'd0);
    checks++; if (p_state !== 4'd0 || bus.pw_set !== 1'b1 || bus.state !== 4'd0) begin
      errors++; $display("FAIL store_submit: state=%0d pw_set=%b, required 0/1", p_state, bus.pw_set); end
  endtask

  task automatic test_unlock();
    int c0, n;
    c0 = cmp_req_cnt;
    attempt(1'b1);
    checks++; if (cmp_req_cnt - c0 !== 1) begin
      errors++; $display("FAIL unlock_cmp_req: pulses=%0d, required 1", cmp_req_cnt - c0); end
    checks++; if (bus.state !== 4'd5 || bus.unlock !== 1'b1 || bus.sec_left !== 8'd10) begin
      errors++; $display("FAIL unlock_enter: state=%0d unlock=%b sec_left=%0d, required 5/1/10", bus.state, bus.unlock, bus.sec_left); end
    wait_idle(n);
    checks++; if (n !== 39) begin
      errors++; $display("FAIL unlock_duration: cycles=%0d, required 40", n + 1); end
    checks++; if (bus.unlock !== 1'b0 || bus.clr_in !== 1'b1 || bus.sec_left !== 8'd0) begin
      errors++; $display("FAIL unlock_exit: unlock=%b clr_in=%b sec_left=%0d, required 0/1/0", bus.unlock, bus.clr_in, bus.sec_left); end
  endtask

  task automatic test_lockout();
    int n;
    attempt(1'b0);
    checks++; if (bus.state !== 4'd0 || bus.attempts !== 3'd1 || bus.clr_in !== 1'b1) begin
      errors++; $display("FAIL lockout_fail1: state=%0d attempts=%0d clr_in=%b, required 0/1/1", bus.state, bus.attempts, bus.clr_in); end
    attempt(1'b0);
    checks++; if (bus.attempts !== 3'd2) begin
      errors++; $display("FAIL lockout_fail2: attempts=%0d, required 2", bus.attempts); end
    attempt(1'b0);
    checks++; if (bus.state !== 4'd6 || bus.locked !== 1'b1 || bus.sec_left !== 8'd5 || bus.attempts !== 3'd0) begin
      errors++; $display("FAIL lockout_enter: state=%0d locked=%b sec_left=%0d attempts=%0d, required 6/1/5/0", bus.state, bus.locked, bus.sec_left, bus.attempts); end
    press(0, 2'd1);
    checks++; if (p_wr_in !== 1'b0 || p_state !== 4'd6) begin
      errors++; $display("FAIL lockout_ignore: wr_in=%b state=%0d, required 0/6", p_wr_in, p_state); end
    wait_idle(n);
    checks++; if (n + 2 !== 20 || bus.locked !== 1'b0 || bus.clr_in !== 1'b1) begin
      errors++; $display("FAIL lockout_duration: cycles=%0d locked=%b clr_in=%b, required 20/0/1", n + 2, bus.locked, bus.clr_in); end
  endtask

  task automatic test_escalate();
    int n;
    attempt(1'b0); attempt(1'b0); attempt(1'b0);
    checks++; if (bus.state !== 4'd6 || bus.sec_left !== 8'd10) begin
      errors++; $display("FAIL escalate_second: state=%0d sec_left=%0d, required 6/10", bus.state, bus.sec_left); end
    wait_idle(n);
    checks++; if (n !== 40) begin
      errors++; $display("FAIL escalate_duration: cycles=%0d, required 40", n); end
    attempt(1'b1);
    // Submit and store together in UNLOCK: submit has priority.
    bus.submit_btn = 1'b1;
    press(1, 2'd2);
    checks++; if (p_state !== 4'd0 || p_wr_sys !== 1'b0 || bus.clr_in !== 1'b0) begin
      errors++; $display("FAIL priority_submit: state=%0d wr_sys=%b, required 0/0", p_state, p_wr_sys); end
    attempt(1'b0); attempt(1'b0); attempt(1'b0);
    checks++; if (bus.state !== 4'd6 || bus.sec_left !== 8'd5) begin
      errors++; $display("FAIL escalate_reset: state=%0d sec_left=%0d, required 6/5", bus.state, bus.sec_left); end
    wait_idle(n);
  endtask

  task automatic test_short_submit();
    int c0;
    press(0, 2'd1);
    checks++; if (p_wr_in !== 1'b1 || p_idx !== 3'd0 || p_state !== 4'd1) begin
      errors++; $display("FAIL enter_first: wr_in=%b idx=%0d state=%0d, required 1/0/1", p_wr_in, p_idx, p_state); end
    press(0, 2'd2);
    checks++; if (p_wr_in !== 1'b1 || p_idx !== 3'd1 || p_data !== 2'd2) begin
      errors++; $display("FAIL enter_second: wr_in=%b idx=%0d data=%0d, required 1/1/2", p_wr_in, p_idx, p_data); end
    c0 = cmp_req_cnt;
    press(2, 2'd0);
    checks++; if (p_state !== 4'd4 || cmp_req_cnt !== c0) begin
      errors++; $display("FAIL short_submit: state=%0d cmp_req_pulses=%0d, required 4/0", p_state, cmp_req_cnt - c0); end
    checks++; if (bus.state !== 4'd0 || bus.attempts !== 3'd1 || bus.clr_in !== 1'b1) begin
      errors++; $display("FAIL short_fail: state=%0d attempts=%0d clr_in=%b, required 0/1/1", bus.state, bus.attempts, bus.clr_in); end
    for (int i = 0; i < 4; i++) press(0, 2'(i));
    press(0, 2'd3);
    checks++; if (p_wr_in !== 1'b0 || p_state !== 4'd1) begin
      errors++; $display("FAIL enter_fifth: wr_in=%b state=%0d, required 0/1", p_wr_in, p_state); end
    press(2, 2'd0);
    bus.cmp_done = 1'b1; bus.match = 1'b1;
    step();
    bus.cmp_done = 1'b0; bus.match = 1'b0;
    checks++; if (bus.state !== 4'd5 || bus.attempts !== 3'd0) begin
      errors++; $display("FAIL unlock_clears_attempts: state=%0d attempts=%0d, required 5/0", bus.state, bus.attempts); end
    press(2, 2'd0);
  endtask

  task automatic test_timeout();
    int n;
    press(0, 2'd1); press(0, 2'd2); press(0, 2'd3);
    press(0, 2'd0);
    press(2, 2'd0);
    checks++; if (p_cmp_req !== 1'b1 || p_state !== 4'd3) begin
      errors++; $display("FAIL timeout_req: cmp_req=%b state=%0d, required 1/3", p_cmp_req, p_state); end
    n = 1;
    while (bus.cmp_err !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    checks++; if (n !== 16 || bus.state !== 4'd4) begin
      errors++; $display("FAIL timeout_err: cycle=%0d state=%0d, required 16/4", n, bus.state); end
    step();
    checks++; if (bus.cmp_err !== 1'b0 || bus.state !== 4'd0 || bus.attempts !== 3'd1) begin
      errors++; $display("FAIL timeout_fail: cmp_err=%b state=%0d attempts=%0d, required 0/0/1", bus.cmp_err, bus.state, bus.attempts); end
  endtask

  task automatic test_pw_change();
    attempt(1'b1);
    press(1, 2'd2);
    checks++; if (p_wr_sys !== 1'b1 || p_idx !== 3'd0 || p_data !== 2'd2 || p_state !== 4'd2 || p_unlock !== 1'b0) begin
      errors++; $display("FAIL pw_change: wr_sys=%b idx=%0d data=%0d state=%0d unlock=%b, required 1/0/2/2/0", p_wr_sys, p_idx, p_data, p_state, p_unlock); end
    press(1, 2'd1); press(1, 2'd1); press(1, 2'd1);
    press(2, 2'd0);
    checks++; if (bus.state !== 4'd0 || bus.pw_set !== 1'b1) begin
      errors++; $display("FAIL pw_change_done: state=%0d pw_set=%b, required 0/1", bus.state, bus.pw_set); end
  endtask

  task automatic test_reset_mid();
    attempt(1'b1);
    system_reset = 1'b1;
    step();
    checks++; if (bus.unlock !== 1'b0 || bus.pw_set !== 1'b0 || bus.state !== 4'd0 || bus.sec_left !== 8'd0) begin
      errors++; $display("FAIL reset_mid: unlock=%b pw_set=%b state=%0d sec_left=%0d, required 0/0/0/0", bus.unlock, bus.pw_set, bus.state, bus.sec_left); end
    system_reset = 1'b0;
    step();
  endtask

  initial begin
    bus.input_btn  = 1'b0;
    bus.store_btn  = 1'b0;
    bus.submit_btn = 1'b0;
    bus.digit      = 2'd0;
    bus.cmp_done   = 1'b0;
    bus.match      = 1'b0;
    test_reset();
    test_store();
    test_unlock();
    test_lockout();
    test_escalate();
    test_short_submit();
    test_timeout();
    test_pw_change();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
